// File: rtl/loopback_fifo.sv
// Byte FIFO between the CDC OUT and IN application ports.
// Holds bytes back until a packet's worth is queued or the writer goes idle.
module loopback_fifo #(
   parameter int DEPTH       = 32,
   parameter int THRESHOLD   = 8,
   parameter int IDLE_CYCLES = 1600
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic [7:0]               rx_data_i,
   input  logic                     rx_valid_i,
   output logic                     rx_ready_o,
   output logic [7:0]               tx_data_o,
   output logic                     tx_valid_o,
   input  logic                     tx_ready_i,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int IW = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;

   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
   localparam logic [LW-1:0] THR_LVL  = LW'(THRESHOLD);
   localparam logic [LW-1:0] ONE_LVL  = LW'(1);
   localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES);

   typedef enum logic {
      HOLD,
      DRAIN
   } state_t;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [LW-1:0] level;
   logic [IW-1:0] idle_cnt;
   state_t        state;
   state_t        state_nx;
   logic          wr;
   logic          rd;
   logic          idle;

   assign full_o     = (level == FULL_LVL);
   assign empty_o    = (level == '0);
   assign rx_ready_o = !full_o;
   assign level_o    = level;
   assign tx_data_o  = mem[rd_ptr];
   assign wr         = rx_valid_i && rx_ready_o;
   assign rd         = tx_valid_o && tx_ready_i;
   assign idle       = (idle_cnt == IDLE_MAX) && !empty_o;

   // storage is deliberately left out of reset
   always_ff @(posedge clk_i) begin
      if (wr) begin
         mem[wr_ptr] <= rx_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (wr && !rd) begin
            level <= level + ONE_LVL;
         end else if (rd && !wr) begin
            level <= level - ONE_LVL;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         idle_cnt <= '0;
      end else if (wr || empty_o) begin
         idle_cnt <= '0;
      end else if (idle_cnt != IDLE_MAX) begin
         idle_cnt <= idle_cnt + IW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state <= HOLD;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      tx_valid_o = 1'b0;
      unique case (state)
         HOLD: begin
            if (level >= THR_LVL || idle || full_o) begin
               state_nx = DRAIN;
            end
         end
         DRAIN: begin
            tx_valid_o = !empty_o;
            // leave only when the last byte goes out with nothing arriving
            if (rd && !wr && level == ONE_LVL) begin
               state_nx = HOLD;
            end
         end
         default: state_nx = HOLD;
      endcase
   end

endmodule

// File: tb/tb_loopback_fifo.sv
// Directed and randomised checks for loopback_fifo.
// Built with a 16-cycle idle timeout so the idle release is quick to reach.
module tb_loopback_fifo;

   logic       clk;
   logic       rstn;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [5:0] level;
   logic       full;
   logic       empty;

   int total = 0;
   int bad   = 0;

   loopback_fifo #(
      .DEPTH(32),
      .THRESHOLD(8),
      .IDLE_CYCLES(16)
   ) dut (
      .clk_i(clk),
      .rstn_i(rstn),
      .rx_data_i(rx_data),
      .rx_valid_i(rx_valid),
      .rx_ready_o(rx_ready),
      .tx_data_o(tx_data),
      .tx_valid_o(tx_valid),
      .tx_ready_i(tx_ready),
      .level_o(level),
      .full_o(full),
      .empty_o(empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rstn     = 1'b0;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      tx_ready = 1'b0;
      cyc();
      cyc();
      total++;
      if ({rx_ready, tx_valid, level, full, empty} !== {1'b1, 1'b0, 6'd0, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL reset_outputs: got rdy=%b vld=%b lvl=%0d full=%b empty=%b want 1 0 0 0 1",
                  rx_ready, tx_valid, level, full, empty);
      end
      rstn = 1'b1;
      cyc();
   endtask

   task automatic test_threshold();
      int n;
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rx_data  = 8'(i + 1);
         rx_valid = 1'b1;
         cyc();
         total++;
         if (tx_valid !== 1'b0) begin
            bad++;
            $display("FAIL thr_hold_%0d: tx_valid=%b want 0", i, tx_valid);
         end
      end
      rx_valid = 1'b0;
      total++;
      if (level !== 6'd8) begin
         bad++;
         $display("FAIL thr_level: level=%0d want 8", level);
      end
      cyc();
      for (int i = 0; i < 8; i++) begin
         total++;
         if (tx_valid !== 1'b1 || tx_data !== 8'(i + 1)) begin
            bad++;
            $display("FAIL thr_out_%0d: vld=%b data=%h want 1 %h", i, tx_valid, tx_data, 8'(i + 1));
         end
         cyc();
      end
      total++;
      if (empty !== 1'b1 || tx_valid !== 1'b0) begin
         bad++;
         $display("FAIL thr_empty: empty=%b vld=%b want 1 0", empty, tx_valid);
      end
      rx_data  = 8'hAA;
      rx_valid = 1'b1;
      cyc();
      rx_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
      end
      total++;
      if (tx_valid !== 1'b0) begin
         bad++;
         $display("FAIL thr_back_in_hold: tx_valid=%b want 0", tx_valid);
      end
      n = 0;
      while (!tx_valid && n < 40) begin
         cyc();
         n++;
      end
      total++;
      if (tx_valid !== 1'b1 || tx_data !== 8'hAA) begin
         bad++;
         $display("FAIL thr_single_idle: vld=%b data=%h want 1 aa", tx_valid, tx_data);
      end
      cyc();
      total++;
      if (empty !== 1'b1) begin
         bad++;
         $display("FAIL thr_single_empty: empty=%b want 1", empty);
      end
   endtask

   task automatic test_idle();
      int n;
      tx_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rx_data  = 8'(8'h11 + i);
         rx_valid = 1'b1;
         cyc();
      end
      rx_valid = 1'b0;
      n = 0;
      while (!tx_valid && n < 40) begin
         cyc();
         n++;
      end
      total++;
      if (n != 17) begin
         bad++;
         $display("FAIL idle_latency: got %0d clocks want 17", n);
      end
      for (int i = 0; i < 3; i++) begin
         total++;
         if (tx_valid !== 1'b1 || tx_data !== 8'(8'h11 + i)) begin
            bad++;
            $display("FAIL idle_out_%0d: vld=%b data=%h want 1 %h", i, tx_valid, tx_data, 8'(8'h11 + i));
         end
         cyc();
      end
      total++;
      if (empty !== 1'b1) begin
         bad++;
         $display("FAIL idle_empty: empty=%b want 1", empty);
      end
   endtask

   task automatic test_full();
      int nin;
      int nout;
      int n;
      tx_ready = 1'b0;
      for (int i = 0; i < 32; i++) begin
         rx_data  = 8'(8'h40 + i);
         rx_valid = 1'b1;
         cyc();
      end
      total++;
      if (full !== 1'b1 || level !== 6'd32 || rx_ready !== 1'b0) begin
         bad++;
         $display("FAIL full_flags: full=%b lvl=%0d rdy=%b want 1 32 0", full, level, rx_ready);
      end
      nin  = 32;
      nout = 0;
      n    = 0;
      tx_ready = 1'b1;
      while (nout < 40 && n < 200) begin
         rx_valid = (nin < 40);
         rx_data  = 8'(8'h40 + nin);
         if (tx_valid) begin
            total++;
            if (tx_data !== 8'(8'h40 + nout)) begin
               bad++;
               $display("FAIL full_out_%0d: data=%h want %h", nout, tx_data, 8'(8'h40 + nout));
            end
            nout++;
         end
         if (rx_valid && rx_ready) begin
            nin++;
         end
         cyc();
         n++;
      end
      rx_valid = 1'b0;
      total++;
      if (nout != 40 || empty !== 1'b1) begin
         bad++;
         $display("FAIL full_drain: got %0d bytes empty=%b want 40 1", nout, empty);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] q[$];
      logic [7:0] e;
      int n;
      tx_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         rx_data  = 8'(8'h60 + i);
         rx_valid = 1'b1;
         q.push_back(rx_data);
         cyc();
      end
      rx_valid = 1'b0;
      cyc();
      for (int i = 0; i < 20; i++) begin
         rx_data  = 8'(8'h80 + i);
         rx_valid = 1'b1;
         tx_ready = 1'b1;
         e = q.pop_front();
         q.push_back(rx_data);
         total++;
         if (tx_valid !== 1'b1 || tx_data !== e) begin
            bad++;
            $display("FAIL b2b_out_%0d: vld=%b data=%h want 1 %h", i, tx_valid, tx_data, e);
         end
         cyc();
         total++;
         if (level !== 6'd10 || tx_valid !== 1'b1) begin
            bad++;
            $display("FAIL b2b_level_%0d: lvl=%0d vld=%b want 10 1", i, level, tx_valid);
         end
      end
      rx_valid = 1'b0;
      n = 0;
      while (q.size() > 0 && n < 50) begin
         if (tx_valid) begin
            e = q.pop_front();
            total++;
            if (tx_data !== e) begin
               bad++;
               $display("FAIL b2b_tail: data=%h want %h", tx_data, e);
            end
         end
         cyc();
         n++;
      end
      total++;
      if (q.size() != 0 || empty !== 1'b1) begin
         bad++;
         $display("FAIL b2b_drain: left=%0d empty=%b want 0 1", q.size(), empty);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      int nout;
      tx_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         rx_data  = 8'(8'hB0 + i);
         rx_valid = 1'b1;
         cyc();
      end
      rx_valid = 1'b0;
      cyc();
      tx_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
      end
      tx_ready = 1'b0;
      total++;
      if (level !== 6'd5 || tx_valid !== 1'b1) begin
         bad++;
         $display("FAIL rst_setup: lvl=%0d vld=%b want 5 1", level, tx_valid);
      end
      #2;
      rstn = 1'b0;
      #1;
      total++;
      if ({tx_valid, level, empty, rx_ready} !== {1'b0, 6'd0, 1'b1, 1'b1}) begin
         bad++;
         $display("FAIL rst_async: vld=%b lvl=%0d empty=%b rdy=%b want 0 0 1 1",
                  tx_valid, level, empty, rx_ready);
      end
      cyc();
      rstn = 1'b1;
      cyc();
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rx_data  = 8'(8'hC0 + i);
         rx_valid = 1'b1;
         cyc();
      end
      rx_valid = 1'b0;
      nout = 0;
      n    = 0;
      while (nout < 8 && n < 40) begin
         if (tx_valid) begin
            total++;
            if (tx_data !== 8'(8'hC0 + nout)) begin
               bad++;
               $display("FAIL rst_burst_%0d: data=%h want %h", nout, tx_data, 8'(8'hC0 + nout));
            end
            nout++;
         end
         cyc();
         n++;
      end
      total++;
      if (nout != 8 || empty !== 1'b1) begin
         bad++;
         $display("FAIL rst_burst_done: got %0d empty=%b want 8 1", nout, empty);
      end
   endtask

   task automatic test_random();
      logic [7:0] q[$];
      logic [7:0] e;
      int nin;
      int nout;
      int n;
      bit wr;
      bit rd;
      nin  = 0;
      nout = 0;
      n    = 0;
      while (nout < 2000 && n < 40000) begin
         rx_valid = (nin < 2000) && ($urandom_range(0, 1) == 1);
         rx_data  = 8'($urandom);
         tx_ready = ($urandom_range(0, 3) != 0);
         wr = rx_valid && rx_ready;
         rd = tx_valid && tx_ready;
         if (rd) begin
            e = q.pop_front();
            total++;
            if (tx_data !== e) begin
               bad++;
               $display("FAIL rand_data_%0d: data=%h want %h", nout, tx_data, e);
            end
            nout++;
         end
         if (wr) begin
            q.push_back(rx_data);
            nin++;
         end
         cyc();
         n++;
         total++;
         if (level !== 6'(q.size())) begin
            bad++;
            $display("FAIL rand_level: lvl=%0d want %0d", level, q.size());
         end
      end
      rx_valid = 1'b0;
      total++;
      if (nout != 2000 || empty !== 1'b1) begin
         bad++;
         $display("FAIL rand_done: got %0d empty=%b want 2000 1", nout, empty);
      end
   endtask

   initial begin
      test_reset();
      test_threshold();
      test_idle();
      test_full();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
